// File: rtl/regfile_dump.sv
// Streams a contiguous address range of a register file out over a valid/ready port.
// Optional REGFILE_DUMP_PARITY_EN adds parity_o, the registered XOR of data_o.
module regfile_dump #(
  parameter int unsigned W = 64,
  parameter int unsigned R = 32,
  localparam int unsigned AW = (R > 1) ? $clog2(R) : 1
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [AW-1:0] first_i,
  input  logic [AW-1:0] last_i,
  output logic [AW-1:0] ra_o,
  input  logic [W-1:0]  rd_i,
  output logic [W-1:0]  data_o,
  output logic [AW-1:0] addr_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          last_o,
  output logic          busy_o,
  output logic          done_o
`ifdef REGFILE_DUMP_PARITY_EN
  ,
  output logic          parity_o
`endif
);

  typedef enum logic [1:0] {StIdle, StFetch, StSend, StDone} state_e;

  localparam logic [AW-1:0] MaxAddr = AW'(R - 1);

  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] end_q;
  logic [W-1:0]  data_q;
  logic [AW-1:0] addr_q;
  logic          valid_q;
  logic          last_q;
  logic          busy_q;
  logic          done_q;
  logic          parity_q;
  logic [AW-1:0] end_lim;

  // Clamp the requested range so the pointer never leaves the populated entries.
  assign end_lim = (last_i > MaxAddr) ? MaxAddr : last_i;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      end_q    <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            ptr_q  <= first_i;
            end_q  <= end_lim;
            busy_q <= 1'b1;
            if (first_i <= end_lim) begin
              state_q <= StFetch;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StFetch: begin
          data_q   <= rd_i;
          parity_q <= ^rd_i;
          addr_q   <= ptr_q;
          last_q   <= (ptr_q == end_q);
          valid_q  <= 1'b1;
          state_q  <= StSend;
        end
        StSend: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (ptr_q == end_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              ptr_q   <= ptr_q + 1'b1;
              state_q <= StFetch;
            end
          end
        end
        StDone: begin
          // ptr doubles as the read address, so park it at 0 while idle.
          ptr_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ra_o    = ptr_q;
  assign data_o  = data_q;
  assign addr_o  = addr_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

`ifdef REGFILE_DUMP_PARITY_EN
  assign parity_o = parity_q;
`else
  logic unused_parity;
  assign unused_parity = parity_q;
`endif

  valid_in_send: assert property (@(posedge clk) disable iff (!rst_ni)
    valid_q |-> (state_q == StSend));

  beat_held: assert property (@(posedge clk) disable iff (!rst_ni)
    (valid_o && !ready_i) |=> (valid_o && $stable(data_o) && $stable(addr_o) && $stable(last_o)));

  ptr_in_range: assert property (@(posedge clk) disable iff (!rst_ni)
    (state_q inside {StFetch, StSend}) |-> (ptr_q <= end_q));

  done_single: assert property (@(posedge clk) disable iff (!rst_ni)
    done_o |=> !done_o);

endmodule
